// File: rtl/kb_pkg.sv
// kb_pkg: shared constants and types for the PS/2 keyboard event queue.
//   KB_PREFIX_EXT / KB_PREFIX_BRK : prefix bytes folded into event flags
//   KB_EV_*                       : event word layout {brk, ext, scancode}
//   kb_rx_state_e                 : PS/2 frame receiver states
package kb_pkg;

  localparam logic [7:0] KB_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] KB_PREFIX_BRK = 8'hF0;

  localparam int KB_EV_BRK = 9;
  localparam int KB_EV_EXT = 8;
  localparam int KB_EV_W   = 10;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } kb_rx_state_e;

endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: PS/2 line conditioning and 11-bit frame receiver.
//   clk         : system clock
//   sclr_i      : synchronous active-high reset
//   ps2_clk_n_i : raw PS/2 clock line (async), data sampled on its fall
//   ps2_dat_i   : raw PS/2 data line (async)
//   byte_en_o   : one-cycle strobe, byte_o holds a checked byte
//   byte_o      : received byte
//   frame_err_o : one-cycle strobe per discarded frame (check or timeout)
//
// state     | meaning
// RX_IDLE   | waiting for a start bit (data low on a clock fall)
// RX_DATA   | shifting in 8 data bits, LSB first
// RX_PARITY | checking odd parity over data + parity bit
// RX_STOP   | checking stop bit, then report byte or error
module ps2_frame_rx
  import kb_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       sclr_i,
  input  logic       ps2_clk_n_i,
  input  logic       ps2_dat_i,
  output logic       byte_en_o,
  output logic [7:0] byte_o,
  output logic       frame_err_o
);

  localparam int FLT_W = $clog2(FILTER_LEN + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);
  localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       clk_sync_q;
  logic [1:0]       dat_sync_q;
  logic             flt_q;
  logic             flt_prev_q;
  logic [FLT_W-1:0] flt_cnt_q;
  logic             sample_en;
  logic             dat_s;

  kb_rx_state_e     state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic             par_ok_q, par_ok_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             byte_en_q, byte_en_d;
  logic [7:0]       byte_q, byte_d;
  logic             frame_err_q, frame_err_d;

  // Lines idle high; resetting the synchronisers and filter high keeps a
  // reset from manufacturing a falling edge.
  always_ff @(posedge clk) begin
    if (sclr_i) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_n_i};
      dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
    end
  end

  // Filtered level flips only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk) begin
    if (sclr_i) begin
      flt_q      <= 1'b1;
      flt_prev_q <= 1'b1;
      flt_cnt_q  <= '0;
    end else begin
      flt_prev_q <= flt_q;
      if (clk_sync_q[1] == flt_q) begin
        flt_cnt_q <= '0;
      end else if (flt_cnt_q == FLT_LAST) begin
        flt_q     <= clk_sync_q[1];
        flt_cnt_q <= '0;
      end else begin
        flt_cnt_q <= flt_cnt_q + FLT_W'(1);
      end
    end
  end

  assign sample_en = flt_prev_q & ~flt_q;
  assign dat_s     = dat_sync_q[1];

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    par_ok_d    = par_ok_q;
    to_cnt_d    = to_cnt_q;
    byte_en_d   = 1'b0;
    byte_d      = byte_q;
    frame_err_d = 1'b0;

    if (sample_en) begin
      to_cnt_d = TO_LOAD;
      case (state_q)
        RX_IDLE: begin
          if (!dat_s) begin
            state_d   = RX_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        RX_DATA: begin
          shift_d   = {dat_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
        end
        RX_PARITY: begin
          // odd parity: XOR over data and parity bit must be 1
          par_ok_d = ^{shift_q, dat_s};
          state_d  = RX_STOP;
        end
        RX_STOP: begin
          if (dat_s && par_ok_q) begin
            byte_en_d = 1'b1;
            byte_d    = shift_q;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d = RX_IDLE;
        end
        default: state_d = RX_IDLE;
      endcase
    end else if (state_q != RX_IDLE) begin
      if (to_cnt_q == '0) begin
        state_d     = RX_IDLE;
        frame_err_d = 1'b1;
        to_cnt_d    = TO_LOAD;
      end else begin
        to_cnt_d = to_cnt_q - TO_W'(1);
      end
    end else begin
      to_cnt_d = TO_LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (sclr_i) begin
      state_q     <= RX_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      par_ok_q    <= 1'b0;
      to_cnt_q    <= TO_LOAD;
      byte_en_q   <= 1'b0;
      byte_q      <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      par_ok_q    <= par_ok_d;
      to_cnt_q    <= to_cnt_d;
      byte_en_q   <= byte_en_d;
      byte_q      <= byte_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign byte_en_o   = byte_en_q;
  assign byte_o      = byte_q;
  assign frame_err_o = frame_err_q;

endmodule

// File: rtl/kb_event_queue.sv
// kb_event_queue: PS/2 keyboard front end with prefix decoding and an
// event FIFO (first-word-fall-through).
//   clk          : system clock
//   i_sclr       : synchronous active-high reset
//   i_ps2_clk_n  : raw PS/2 clock line
//   i_ps2_dat    : raw PS/2 data line
//   i_pop        : consumer takes the head event
//   o_valid      : FIFO not empty
//   o_event      : {brk, ext, scancode}, 0 while empty
//   o_count      : FIFO occupancy 0..DEPTH
//   o_overflow   : sticky, an event was dropped on a full FIFO
//   o_frame_err  : one-cycle pulse per discarded frame
module kb_event_queue
  import kb_pkg::*;
#(
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                     clk,
  input  logic                     i_sclr,
  input  logic                     i_ps2_clk_n,
  input  logic                     i_ps2_dat,
  input  logic                     i_pop,
  output logic                     o_valid,
  output logic [KB_EV_W-1:0]       o_event,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow,
  output logic                     o_frame_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic               rx_byte_en;
  logic [7:0]         rx_byte;
  logic               rx_frame_err;

  logic               ext_q, ext_d;
  logic               brk_q, brk_d;
  logic               push_q, push_d;
  logic [KB_EV_W-1:0] push_ev_q, push_ev_d;

  logic [KB_EV_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               full, empty, do_push, do_pop;

  ps2_frame_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk         (clk),
    .sclr_i      (i_sclr),
    .ps2_clk_n_i (i_ps2_clk_n),
    .ps2_dat_i   (i_ps2_dat),
    .byte_en_o   (rx_byte_en),
    .byte_o      (rx_byte),
    .frame_err_o (rx_frame_err)
  );

  // Prefix bytes only arm flags; the next ordinary byte carries them out.
  always_comb begin
    ext_d     = ext_q;
    brk_d     = brk_q;
    push_d    = 1'b0;
    push_ev_d = push_ev_q;
    if (rx_frame_err) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (rx_byte_en) begin
      if (rx_byte == KB_PREFIX_EXT) begin
        ext_d = 1'b1;
      end else if (rx_byte == KB_PREFIX_BRK) begin
        brk_d = 1'b1;
      end else begin
        push_d               = 1'b1;
        push_ev_d            = '0;
        push_ev_d[KB_EV_BRK] = brk_q;
        push_ev_d[KB_EV_EXT] = ext_q;
        push_ev_d[7:0]       = rx_byte;
        ext_d                = 1'b0;
        brk_d                = 1'b0;
      end
    end
  end

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = i_pop && !empty;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts.
  assign do_push = push_q && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (push_q && !do_push) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (i_sclr) begin
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      push_q    <= 1'b0;
      push_ev_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      ext_q     <= ext_d;
      brk_q     <= brk_d;
      push_q    <= push_d;
      push_ev_q <= push_ev_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage needs no reset: reads are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_ev_q;
  end

  assign o_valid     = !empty;
  assign o_event     = empty ? '0 : mem_q[rd_ptr_q];
  assign o_count     = count_q;
  assign o_overflow  = ovf_q;
  assign o_frame_err = rx_frame_err;

endmodule

// File: doc/kb_event_queue.md
# kb_event_queue

Parametrised PS/2 keyboard front end: conditions the raw PS/2 clock and data lines, receives 11-bit frames with full framing and parity checks, and folds `E0`/`F0` prefix bytes into single key events. Events are buffered in a first-word-fall-through FIFO with a valid/pop handshake. It sits between the board PS/2 pins and any consumer of key events (LED/hex debug, text buffer, game logic). It supersedes the bare byte-to-scancode path by adding make/break and extended decoding, error reporting, timeout recovery and buffering.

## Interface
- `DEPTH`, 8: FIFO entries; must be a power of two and ≥ 2.
- `FILTER_LEN`, 4: consecutive equal synchronised samples required before the filtered PS/2 clock changes level.
- `TIMEOUT_CYCLES`, 50000: `clk` cycles without a PS/2 clock falling edge that abort a frame in progress.
- `clk` in 1: system clock; the only clock.
- `i_sclr` in 1: reset; synchronous, active-high.
- `i_ps2_clk_n` in 1: raw PS/2 clock line, asynchronous to `clk`; data is sampled on its falling edge.
- `i_ps2_dat` in 1: raw PS/2 data line, asynchronous.
- `i_pop` in 1: consumer takes the head event.
- `o_valid` out 1: FIFO not empty; `o_event` is valid.
- `o_event` out 10: [9] break (release), [8] extended, [7:0] scancode.
- `o_count` out clog2(DEPTH)+1: current FIFO occupancy.
- `o_overflow` out 1: sticky; an event was dropped because the FIFO was full.
- `o_frame_err` out 1: one-cycle pulse per discarded frame.

## Operation
- Each input passes through a 2-flop synchroniser. The clock line then passes through the `FILTER_LEN` glitch filter. A 1→0 transition of the filtered clock produces a one-cycle sample enable.
- The frame FSM has states IDLE, DATA, PARITY and STOP, and advances only on the sample enable.
  - IDLE: data = 0 goes to DATA; data = 1 stays in IDLE with no error.
  - DATA: captures 8 bits LSB-first, then goes to PARITY.
  - PARITY: the 8 data bits plus the parity bit must have odd parity.
  - STOP: stop bit = 1 gives byte_en; any failure gives a frame error. Both return to IDLE.
- Timeout: the counter runs in any non-IDLE state and clears on each sample enable. Reaching `TIMEOUT_CYCLES` goes to IDLE, discards the partial frame and raises a frame error.
- The decoder holds flags `ext` and `brk`, both 0 at reset.
  - Byte `E0` sets `ext`.
  - Byte `F0` sets `brk`.
  - Any other byte, including `E1`, pushes the event {brk, ext, byte} and clears both flags.
  - A frame error clears both flags.
- FIFO:
  - Push on each event.
  - Pop when `i_pop && o_valid`. A pop while empty is ignored.
  - A push while full is dropped and sets `o_overflow`. Existing contents are untouched.
  - Push and pop in the same cycle while full: both take effect and the new event is stored. `o_overflow` is not set and `o_count` is unchanged.
  - Pointers wrap modulo `DEPTH`. `o_count` ranges 0..DEPTH.
- `o_event` reads 0 while `o_valid` = 0.

## Timing
- Reset values: `o_valid`, `o_count`, `o_overflow`, `o_frame_err` and `o_event` are all 0. FSM is IDLE, flags are clear, FIFO is empty.
- Reset mid-frame or with a non-empty FIFO discards everything. The first edge after reset is treated as IDLE.
- Input latency: a pin change reaches the filtered clock after 2 synchroniser cycles plus `FILTER_LEN` cycles.
- Let T be the cycle of the sample enable for the stop bit.
  - The byte is registered in T+1.
  - The FIFO write happens at the end of T+2. `o_valid` and `o_count` update in T+3.
- `o_frame_err` is high for exactly one cycle, T+1, on a check failure. On a timeout it is high in the cycle after the count is reached.
- Pop: `o_event` and `o_count` reflect the pop in the next cycle. Back-to-back pops on consecutive cycles are legal.
- `o_overflow` clears only on `i_sclr`.

## Structure
- Package `kb_pkg` holds:
  - `KB_PREFIX_EXT` = 8'hE0 and `KB_PREFIX_BRK` = 8'hF0.
  - The event field indices `KB_EV_BRK` = 9, `KB_EV_EXT` = 8 and `KB_EV_W` = 10.
  - The frame FSM state enum.
- Sub-module `ps2_frame_rx`: synchronisers, glitch filter, edge detect, frame FSM and timeout. Outputs are `byte_en`, `byte` and `frame_err`.
- The top level holds the prefix decoder and the FIFO.

## Test plan
- Valid frame carrying 8'h1C (correct parity) → `o_valid` = 1 and `o_event` = 10'h01C in T+3; `o_count` = 1; pop → `o_valid` = 0 and `o_count` = 0.
- Frames F0, 1C → exactly one event, 10'h21C. Frames E0, F0, 75 → exactly one event, 10'h375. Frames E0, 75 → 10'h175.
- Frame 8'h1C with wrong parity → one `o_frame_err` pulse and no event. Next, F0 with a bad stop bit followed by a good 1C → event 10'h01C, because the flags were cleared.
- `DEPTH` = 4: push 5 make codes 15, 1D, 24, 2D, 2C with no pops → `o_count` = 4 and `o_overflow` = 1. Pops yield 015, 01D, 024, 02D in order. A push coinciding with a pop while full stores the event with no overflow.
- Stop the PS/2 clock after 5 data bits, wait `TIMEOUT_CYCLES` → one `o_frame_err` pulse and FSM in IDLE. A following full 1C frame → 10'h01C.
- Assert `i_sclr` mid-frame with 2 events queued → all outputs 0 next cycle. A subsequent valid frame is received correctly.
